bayer_gray_stream: RTL and testbench
====================================

# bayer_gray_stream

Stream source for the edge-detection pipeline. Accepts the raw 12-bit Bayer pixel stream from the camera capture (RAW_W x RAW_H, one pixel per `raw_valid`). Collapses each 2x2 Bayer quad (R, G1, G2, B) into one grayscale pixel. Emits the half-resolution stream (`gray_valid`, `gray_pixel`, pre-halved `gray_x`/`gray_y`) that the Sobel stage consumes directly.

## Interface
Parameters:
- RAW_W, 1280, raw pixels per line (even)
- RAW_H, 960, raw lines per frame (even)
- PIX_W, 12, pixel width

Ports:
- clk  in  1  single system clock
- rst  in  1  asynchronous, active-high reset
- raw_valid  in  1  raw pixel/coordinate qualifier
- raw_pixel  in  PIX_W  raw Bayer sample
- raw_x  in  11  raw column, 0..RAW_W-1
- raw_y  in  11  raw line, 0..RAW_H-1
- gray_valid  out  1  one-cycle pulse per output pixel
- gray_pixel  out  PIX_W  grayscale value
- gray_x  out  10  raw_x>>1 of the quad
- gray_y  out  10  raw_y>>1 of the quad

## Operation
- Line buffer holds one raw line (RAW_W x PIX_W), addressed by raw_x.
  - Written on every accepted pixel.
  - Read-first: a read returns the previous line's sample at that column.
- Accepted pixel: raw_valid=1 and raw_x<RAW_W and raw_y<RAW_H. Other cycles cause no write, no register update, no output.
- Column-hold registers, updated only on accepted pixels (in stage 1):
  - cur_prev: previous current-line sample.
  - abv_prev: previous above-line sample.
- Qualifying pixel: accepted, raw_x[0]=1, raw_y[0]=1, and sync state is SYNC.
  - Quad = {abv_prev, above, cur_prev, cur}.
  - sum = zero-extended 4-term add, PIX_W+2 bits; no overflow possible.
  - gray_pixel = sum>>2, truncating with no rounding. Saturation is never needed.
- Sync FSM, two states:
  - UNSYNC (reset state): pipeline runs and writes the line buffer, but no output is produced.
  - UNSYNC -> SYNC on an accepted pixel with raw_x=0 and raw_y=0.
  - SYNC -> UNSYNC only on rst.
  - Guarantees the line buffer holds a coherent previous line before the first output.
- Reset mid-frame:
  - Pipeline valids, hold registers and FSM clear.
  - Line buffer contents are not cleared; they are don't-care.
  - Output resumes only after the next frame start (x=0, y=0).
- Raw line 0 of each frame produces no output, since y is even. The read data from the line buffer on line 0 is unused.
- Output count per frame: (RAW_W/2)*(RAW_H/2).
  - gray_x wraps RAW_W/2-1 -> 0 with gray_y incrementing.
  - gray_y wraps at end of frame following the raw coordinates; no internal counters.

## Timing
- Two-stage pipeline, fixed latency 2.
  - Qualifying pixel accepted at cycle N -> gray_valid=1 at cycle N+2.
  - gray_pixel, gray_x and gray_y are valid in that same cycle.
- Stage 1 (N+1): line-buffer read data, registered cur, raw_x, raw_y, qualify bit.
- Stage 2 (N+2): registered sum>>2 and coordinates.
- gray_valid is high exactly one cycle per qualifying pixel, regardless of gaps in raw_valid. Gapped input yields results identical to contiguous input.
- gray_pixel/gray_x/gray_y hold their last values while gray_valid=0.
- Reset values:
  - gray_valid=0, gray_pixel=0, gray_x=0, gray_y=0.
  - FSM=UNSYNC, hold registers 0.
- Throughput: one raw pixel per clock, sustained; no backpressure.

## Structure
- Shared package `cam_pkg`:
  - PIX_W
  - RAW_W/RAW_H defaults
  - derived GRAY_W/GRAY_H
  - sync-state enum {UNSYNC, SYNC}
- One sub-module: `line_buffer`.
  - Single-port read-first synchronous RAM, depth RAW_W, width PIX_W, with write enable and 1-cycle read latency.
  - Inferable as block RAM.

## Test plan
- Params RAW_W=8, RAW_H=4; frame start then constant 0x800 on all pixels -> exactly 8 gray_valid pulses, all 0x800, coords (0,0)..(3,1) in raster order, each 2 cycles after its odd/odd raw pixel.
- Bayer pattern R=4000, G1=G2=1000, B=0 -> every gray_pixel = 1500 (0x5DC).
- All raw pixels 0xFFF -> gray_pixel=0xFFF, no wrap. Quad {1,1,1,0} -> gray_pixel=0 (truncation).
- raw_valid asserted every 3rd cycle with the same frame -> output values and coordinates identical to the contiguous run; each pulse is 1 cycle wide.
- rst pulsed at raw (5,3) mid-frame, stream continues -> no gray_valid until the next (0,0); the following frame is correct. All outputs 0 during and immediately after rst.
- Pixels with raw_x>=RAW_W or raw_valid=0 while random data toggles -> no line-buffer write, no gray_valid, hold registers unchanged.

Source files
------------

// File: rtl/cam_pkg.sv
`default_nettype none
// ============================================================================
// cam_pkg : shared camera-pipeline constants, derived sizes and sync state
// Rev 1.0 : initial release
// ============================================================================
package cam_pkg;

  localparam int PIX_W  = 12;
  localparam int RAW_W  = 1280;
  localparam int RAW_H  = 960;
  localparam int GRAY_W = RAW_W / 2;
  localparam int GRAY_H = RAW_H / 2;

  typedef enum logic [0:0] {
    UNSYNC = 1'b0,
    SYNC   = 1'b1
  } sync_state_e;

  // Bottom-right sample of a 2x2 Bayer quad completes the quad.
  function automatic logic quad_complete(input logic x0, input logic y0);
    return x0 & y0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bayer_gray_stream_if.sv
`default_nettype none
// ============================================================================
// bayer_gray_stream_if : raw Bayer input stream and half-res gray output stream
// Rev 1.0 : initial release
// ============================================================================
interface bayer_gray_stream_if #(
  parameter int PIX_W = cam_pkg::PIX_W
);
  logic             raw_valid;
  logic [PIX_W-1:0] raw_pixel;
  logic [10:0]      raw_x;
  logic [10:0]      raw_y;

  logic             gray_valid;
  logic [PIX_W-1:0] gray_pixel;
  logic [9:0]       gray_x;
  logic [9:0]       gray_y;

  modport master (
    output raw_valid, raw_pixel, raw_x, raw_y,
    input  gray_valid, gray_pixel, gray_x, gray_y
  );

  modport slave (
    input  raw_valid, raw_pixel, raw_x, raw_y,
    output gray_valid, gray_pixel, gray_x, gray_y
  );
endinterface
`default_nettype wire

// File: rtl/bayer_gray_stream_line_buffer.sv
`default_nettype none
// ============================================================================
// line_buffer : single-port read-first RAM holding one raw line, 1-cycle read
// Rev 1.0 : initial release
// ============================================================================
module line_buffer #(
  parameter int DEPTH = cam_pkg::RAW_W,
  parameter int WIDTH = cam_pkg::PIX_W,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             en_i,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Read-first: the old contents (previous line) come out while the new sample goes in.
  always_ff @(posedge clk) begin
    if (en_i) begin
      rdata_q <= mem_q[addr_i];
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/bayer_gray_stream.sv
`default_nettype none
// ============================================================================
// bayer_gray_stream : collapses 2x2 Bayer quads into one gray pixel, latency 2
// Rev 1.0 : initial release
// ============================================================================
module bayer_gray_stream #(
  parameter int RAW_W = cam_pkg::RAW_W,
  parameter int RAW_H = cam_pkg::RAW_H,
  parameter int PIX_W = cam_pkg::PIX_W
) (
  input  logic                clk,
  input  logic                rst,
  bayer_gray_stream_if.slave  bus
);
  import cam_pkg::*;

  localparam int          AW    = (RAW_W > 1) ? $clog2(RAW_W) : 1;
  localparam int          SUM_W = PIX_W + 2;
  localparam logic [10:0] X_LIM = 11'(RAW_W);
  localparam logic [10:0] Y_LIM = 11'(RAW_H);

  logic             acc;
  logic             frame_start;
  logic             qual;
  logic [PIX_W-1:0] above;
  logic [SUM_W-1:0] sum;

  sync_state_e      state_q, state_d;

  logic             s1_valid_q;
  logic             s1_qual_q;
  logic [PIX_W-1:0] s1_cur_q;
  logic [9:0]       s1_gx_q;
  logic [9:0]       s1_gy_q;

  logic [PIX_W-1:0] cur_prev_q;
  logic [PIX_W-1:0] abv_prev_q;

  logic             gray_valid_q;
  logic [PIX_W-1:0] gray_pixel_q;
  logic [9:0]       gray_x_q;
  logic [9:0]       gray_y_q;

  assign acc         = bus.raw_valid && (bus.raw_x < X_LIM) && (bus.raw_y < Y_LIM);
  assign frame_start = acc && (bus.raw_x == 11'd0) && (bus.raw_y == 11'd0);
  assign qual        = acc && quad_complete(bus.raw_x[0], bus.raw_y[0]) && (state_q == SYNC);

  always_comb begin
    state_d = state_q;
    if (frame_start) begin
      state_d = SYNC;
    end
  end

  // Output stays off until a frame start guarantees a coherent previous line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= UNSYNC;
    end else begin
      state_q <= state_d;
    end
  end

  line_buffer #(
    .DEPTH (RAW_W),
    .WIDTH (PIX_W),
    .AW    (AW)
  ) u_line_buffer (
    .clk     (clk),
    .en_i    (acc),
    .we_i    (acc),
    .addr_i  (bus.raw_x[AW-1:0]),
    .wdata_i (bus.raw_pixel),
    .rdata_o (above)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_qual_q  <= 1'b0;
      s1_cur_q   <= '0;
      s1_gx_q    <= '0;
      s1_gy_q    <= '0;
    end else begin
      s1_valid_q <= acc;
      s1_qual_q  <= qual;
      if (acc) begin
        s1_cur_q <= bus.raw_pixel;
        s1_gx_q  <= bus.raw_x[10:1];
        s1_gy_q  <= bus.raw_y[10:1];
      end
    end
  end

  // Left column of the quad, captured as each accepted pixel leaves stage 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_prev_q <= '0;
      abv_prev_q <= '0;
    end else if (s1_valid_q) begin
      cur_prev_q <= s1_cur_q;
      abv_prev_q <= above;
    end
  end

  assign sum = SUM_W'(abv_prev_q) + SUM_W'(above) + SUM_W'(cur_prev_q) + SUM_W'(s1_cur_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gray_valid_q <= 1'b0;
      gray_pixel_q <= '0;
      gray_x_q     <= '0;
      gray_y_q     <= '0;
    end else if (s1_valid_q && s1_qual_q) begin
      gray_valid_q <= 1'b1;
      gray_pixel_q <= PIX_W'(sum >> 2);
      gray_x_q     <= s1_gx_q;
      gray_y_q     <= s1_gy_q;
    end else begin
      gray_valid_q <= 1'b0;
    end
  end

  assign bus.gray_valid = gray_valid_q;
  assign bus.gray_pixel = gray_pixel_q;
  assign bus.gray_x     = gray_x_q;
  assign bus.gray_y     = gray_y_q;

endmodule
`default_nettype wire

// File: tb/tb_bayer_gray_stream.sv
`default_nettype none
// ============================================================================
// tb_bayer_gray_stream : random/pattern frames against an image-level quad model
// Rev 1.0 : initial release
// ============================================================================
module tb_bayer_gray_stream;

  localparam int RAW_W  = 8;
  localparam int RAW_H  = 4;
  localparam int PIX_W  = 12;
  localparam int GRAY_N = (RAW_W / 2) * (RAW_H / 2);

  typedef struct {
    int due;
    int gx;
    int gy;
    int val;
    int lit;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bayer_gray_stream_if #(.PIX_W(PIX_W)) bus ();

  bayer_gray_stream #(
    .RAW_W (RAW_W),
    .RAW_H (RAW_H),
    .PIX_W (PIX_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   pulses = 0;
  int   img [RAW_H][RAW_W];
  bit   synced = 1'b0;
  exp_t q[$];
  int   last_pix = 0;
  int   last_x = 0;
  int   last_y = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int pix_of(input int mode, input int x, input int y);
    case (mode)
      0: return 'h800;
      1: return (x % 2 == 0 && y % 2 == 0) ? 4000 : ((x % 2 == 1 && y % 2 == 1) ? 0 : 1000);
      2: return 'hFFF;
      3: return (x % 2 == 1 && y % 2 == 1) ? 0 : 1;
      default: return int'($urandom_range(0, 4095));
    endcase
  endfunction

  function automatic int lit_of(input int mode);
    case (mode)
      0: return 'h800;
      1: return 1500;
      2: return 'hFFF;
      3: return 0;
      default: return -1;
    endcase
  endfunction

  // Reference: a completed quad averages the four samples of the current frame image.
  task automatic drive(input bit v, input int x, input int y, input int p, input int lit);
    exp_t e;
    @(posedge clk);
    #1;
    bus.raw_valid = v;
    bus.raw_x     = 11'(x);
    bus.raw_y     = 11'(y);
    bus.raw_pixel = PIX_W'(p);
    if (v && x < RAW_W && y < RAW_H) begin
      if (x == 0 && y == 0) synced = 1'b1;
      img[y][x] = p;
      if (synced && (x % 2 == 1) && (y % 2 == 1)) begin
        e.due = cyc + 2;
        e.gx  = x / 2;
        e.gy  = y / 2;
        e.val = (img[y-1][x-1] + img[y-1][x] + img[y][x-1] + img[y][x]) / 4;
        e.lit = lit;
        q.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(1'b0, int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)),
            int'($urandom_range(0, 4095)), -1);
  endtask

  task automatic junk();
    case ($urandom_range(0, 2))
      0: drive(1'b1, int'($urandom_range(RAW_W, 2047)), int'($urandom_range(0, RAW_H - 1)),
               int'($urandom_range(0, 4095)), -1);
      1: drive(1'b1, int'($urandom_range(0, RAW_W - 1)), int'($urandom_range(RAW_H, 2047)),
               int'($urandom_range(0, 4095)), -1);
      default: drive(1'b0, int'($urandom_range(0, RAW_W - 1)), int'($urandom_range(0, RAW_H - 1)),
                     int'($urandom_range(0, 4095)), -1);
    endcase
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.raw_valid = 1'b0;
    q.delete();
    synced   = 1'b0;
    last_pix = 0;
    last_x   = 0;
    last_y   = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // gap < 0 selects a random gap of 0..2 idle cycles per pixel.
  task automatic send_frame(input int mode, input int gap, input bit with_junk, input bit rst_mid);
    int base;
    bit did_rst;
    int g;
    base    = pulses;
    did_rst = 1'b0;
    for (int y = 0; y < RAW_H; y++) begin
      for (int x = 0; x < RAW_W; x++) begin
        if (rst_mid && x == 5 && y == 3) begin
          do_reset();
          base    = pulses;
          did_rst = 1'b1;
        end
        drive(1'b1, x, y, pix_of(mode, x, y), lit_of(mode));
        g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
        idle(g);
        if (with_junk && (x % 2 == 0)) junk();
      end
    end
    idle(4);
    if (did_rst) chk("post_reset_pulses", pulses - base, 0);
    else         chk("frame_pulses", pulses - base, GRAY_N);
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit   ev;
    ev = (q.size() > 0) && (q[0].due == cyc);
    chk("gray_valid", int'(bus.gray_valid), int'(ev));
    if (bus.gray_valid) pulses++;
    if (ev) begin
      e = q.pop_front();
      last_pix = e.val;
      last_x   = e.gx;
      last_y   = e.gy;
      chk("gray_pixel", int'(bus.gray_pixel), e.val);
      chk("gray_x", int'(bus.gray_x), e.gx);
      chk("gray_y", int'(bus.gray_y), e.gy);
      if (e.lit >= 0) chk("pixel_literal", int'(bus.gray_pixel), e.lit);
    end else begin
      chk("hold_pixel", int'(bus.gray_pixel), last_pix);
      chk("hold_x", int'(bus.gray_x), last_x);
      chk("hold_y", int'(bus.gray_y), last_y);
    end
  end

  initial begin
    int base;
    rst = 1'b1;
    bus.raw_valid = 1'b0;
    bus.raw_x     = '0;
    bus.raw_y     = '0;
    bus.raw_pixel = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Tail of a frame before any frame start must stay silent.
    base = pulses;
    for (int y = 2; y < RAW_H; y++)
      for (int x = 0; x < RAW_W; x++)
        drive(1'b1, x, y, int'($urandom_range(0, 4095)), -1);
    idle(4);
    chk("presync_pulses", pulses - base, 0);

    send_frame(0, 0, 1'b0, 1'b0);
    send_frame(1, 0, 1'b0, 1'b0);
    send_frame(2, 0, 1'b0, 1'b0);
    send_frame(3, 0, 1'b0, 1'b0);
    send_frame(0, 2, 1'b0, 1'b0);
    send_frame(1, 2, 1'b1, 1'b0);
    send_frame(4, 0, 1'b1, 1'b0);
    send_frame(4, 0, 1'b0, 1'b1);
    send_frame(4, -1, 1'b1, 1'b0);
    send_frame(4, 0, 1'b0, 1'b0);
    send_frame(3, -1, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
